// File: rtl/packet_reader_pkg.sv
// Shared types and constants for the packet reader and its FIFO write-side peer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package packet_reader_pkg;

    // Payload bytes per packet; the FIFO writer sizes its bursts from the same value.
    localparam int DEF_BYTES_PER_PKT = 4;

    // Default width of the accepted-packet counter.
    localparam int DEF_CNT_W = 16;

    // Reader FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        OUT     = 2'd3
    } state_t;

    // Width needed to index n items, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/packet_reader.sv
// Pops BYTES_PER_PKT bytes from a FIFO and presents them as one word, first byte in the MSBs.
// Latency: 2*BYTES_PER_PKT cycles from first rd to out_valid; one packet per 2*BYTES_PER_PKT+1 cycles.
// Backpressure: holds the word in OUT until out_ready; stalls in READ while the FIFO is empty.
module packet_reader
    import packet_reader_pkg::*;
#(
    parameter int BYTES_PER_PKT = DEF_BYTES_PER_PKT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                       clk_50,
    input  logic                       reset_n,
    input  logic                       empty,
    input  logic [7:0]                 rd_data,
    output logic                       rd,
    input  logic                       flush,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [8*BYTES_PER_PKT-1:0] out_word,
    output logic [CNT_W-1:0]           pkt_count
);

    localparam int              WORD_W   = 8 * BYTES_PER_PKT;
    localparam int              BC_W     = idx_width(BYTES_PER_PKT);
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(BYTES_PER_PKT - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [BC_W-1:0]   r_byte_cnt;
    logic [WORD_W-1:0] r_asm;
    logic [CNT_W-1:0]  r_pkt_count;

    logic w_rd;
    logic w_flush_act;
    logic w_accept;
    logic w_capture;
    logic w_last_byte;

    // A completed word is never dropped, so flush only acts outside OUT.
    assign w_flush_act = flush && (r_state != OUT);
    assign w_accept    = (r_state == OUT) && out_ready;
    // A flush in CAPTURE discards the byte arriving this cycle.
    assign w_capture   = (r_state == CAPTURE) && !flush;
    assign w_last_byte = (r_byte_cnt == LAST_IDX);

    // Next-state decode and read strobe; rd only ever rises in READ with data available.
    always_comb begin
        w_next_state = r_state;
        w_rd         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!flush && !empty) begin
                    w_next_state = READ;
                end
            end
            READ: begin
                if (flush) begin
                    w_next_state = IDLE;
                end else if (!empty) begin
                    w_rd         = 1'b1;
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (flush) begin
                    w_next_state = IDLE;
                end else if (w_last_byte) begin
                    w_next_state = OUT;
                end else begin
                    w_next_state = READ;
                end
            end
            OUT: begin
                if (out_ready) begin
                    w_next_state = empty ? IDLE : READ;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Byte counter: counts captured bytes, held at the last index while the word waits in OUT.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_cnt <= '0;
        end else if (w_flush_act || w_accept) begin
            r_byte_cnt <= '0;
        end else if (w_capture && !w_last_byte) begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
        end
    end

    // Assembly shift register: new bytes enter at the LSB side, earlier bytes move up.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_asm <= '0;
        end else if (w_flush_act || w_accept) begin
            r_asm <= '0;
        end else if (w_capture) begin
            r_asm <= (r_asm << 8) | WORD_W'(rd_data);
        end
    end

    // Packet counter: one per accepted word, wraps silently.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_count <= '0;
        end else if (w_accept) begin
            r_pkt_count <= r_pkt_count + 1'b1;
        end
    end

    assign rd        = w_rd;
    assign out_valid = (r_state == OUT);
    assign out_word  = out_valid ? r_asm : '0;
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_packet_reader.sv
// Self-checking bench for packet_reader: FIFO model, word scoreboard, per-cycle output rules.
// Latency: checks 2*BYTES_PER_PKT first-rd-to-valid and 2*BYTES_PER_PKT+1 packet period.
// Backpressure: exercises out_ready low in OUT and FIFO underflow mid-packet.
module tb_packet_reader;

    logic        clk_50 = 1'b0;
    logic        reset_n;
    logic        empty;
    logic [7:0]  rd_data;
    logic        rd;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_word;
    logic [15:0] pkt_count;

    // Second instance with a 2-bit counter, driven by the same stimulus, for wrap checks.
    logic        rd2;
    logic        ov2;
    logic [31:0] ow2;
    logic [1:0]  pkt_count2;

    always #10 clk_50 = ~clk_50;

    packet_reader #(.BYTES_PER_PKT(4), .CNT_W(16)) dut (
        .clk_50    (clk_50),
        .reset_n   (reset_n),
        .empty     (empty),
        .rd_data   (rd_data),
        .rd        (rd),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .pkt_count (pkt_count)
    );

    packet_reader #(.BYTES_PER_PKT(4), .CNT_W(2)) dut_wrap (
        .clk_50    (clk_50),
        .reset_n   (reset_n),
        .empty     (empty),
        .rd_data   (rd_data),
        .rd        (rd2),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (ov2),
        .out_word  (ow2),
        .pkt_count (pkt_count2)
    );

    logic [7:0]  fifo_q[$];
    logic [31:0] exp_q[$];

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          model_cnt;
    int          rd_total;
    int          first_rd;
    int          n_rise;
    int          rise_cyc[4];
    int          start_cyc;
    bit          prev_valid;
    bit          stall_prev;
    logic [31:0] stall_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        empty = 1'b0;
    endtask

    // Rules that hold on every cycle, judged against the bench's own packet count.
    task automatic check_cycle();
        if (!reset_n) begin
            model_cnt = 0;
            chk("rst_rd", {31'd0, rd}, 32'd0);
            chk("rst_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_word", out_word, 32'd0);
            chk("rst_count", {16'd0, pkt_count}, 32'd0);
            chk("rst_count_wrap", {30'd0, pkt_count2}, 32'd0);
            chk("rst_rd_wrap", {31'd0, rd2}, 32'd0);
            chk("rst_valid_wrap", {31'd0, ov2}, 32'd0);
            chk("rst_word_wrap", ow2, 32'd0);
        end else begin
            if (empty) begin
                chk("rd_while_empty", {31'd0, rd}, 32'd0);
                chk("rd_while_empty_wrap", {31'd0, rd2}, 32'd0);
            end
            if (out_valid === 1'b1) begin
                chk("rd_in_out", {31'd0, rd}, 32'd0);
            end else begin
                chk("word_zero_when_invalid", out_word, 32'd0);
            end
            if (ov2 !== 1'b1) begin
                chk("word_zero_when_invalid_wrap", ow2, 32'd0);
            end
            if (stall_prev) begin
                chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_hold_word", out_word, stall_word);
            end
            chk("pkt_count", {16'd0, pkt_count}, model_cnt & 32'hFFFF);
            chk("pkt_count_wrap", {30'd0, pkt_count2}, model_cnt & 32'h3);
        end
    endtask

    // One clock: sample at the falling edge, then act as the FIFO and scoreboard after the rising edge.
    task automatic step();
        bit          do_pop;
        bit          hs;
        logic [31:0] hs_word;
        @(negedge clk_50);
        cyc++;
        check_cycle();
        if (rd === 1'b1) begin
            rd_total++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (out_valid === 1'b1 && !prev_valid && n_rise < 4) begin
            rise_cyc[n_rise] = cyc;
            n_rise++;
        end
        prev_valid = (out_valid === 1'b1);
        stall_prev = (out_valid === 1'b1) && !out_ready;
        stall_word = out_word;
        do_pop     = (rd === 1'b1);
        hs         = (out_valid === 1'b1) && out_ready && reset_n;
        hs_word    = out_word;
        @(posedge clk_50);
        #1;
        if (do_pop) begin
            if (fifo_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_from_empty: rd was 1, required 0 with no data (cycle %0d)", cyc);
            end else begin
                rd_data = fifo_q.pop_front();
            end
        end
        empty = (fifo_q.size() == 0);
        if (hs) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%0h, required no word (cycle %0d)", hs_word, cyc);
            end else begin
                chk("word", hs_word, exp_q.pop_front());
            end
            model_cnt++;
        end
    endtask

    task automatic wait_cnt(input int target, input int budget, input string name);
        int n = 0;
        while (model_cnt != target && n < budget) begin
            step();
            n++;
        end
        chk(name, model_cnt, target);
    endtask

    task automatic wait_vld(input int budget, input string name);
        int n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(name, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        empty      = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b1;
        rd_data    = 8'h00;
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        model_cnt  = 0;
        rd_total   = 0;
        first_rd   = -1;
        n_rise     = 0;
        prev_valid = 1'b0;
        stall_prev = 1'b0;
        stall_word = 32'd0;

        // Reset state
        repeat (3) step();
        chk("reset_rd", {31'd0, rd}, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_word", out_word, 32'd0);
        chk("reset_count", {16'd0, pkt_count}, 32'd0);
        reset_n = 1'b1;
        repeat (2) step();

        // Back-to-back packets from a preloaded FIFO
        rd_total  = 0;
        first_rd  = -1;
        n_rise    = 0;
        start_cyc = cyc;
        for (int i = 0; i < 8; i++) push(8'(8'hA5 + i));
        exp_q.push_back(32'hA5A6A7A8);
        exp_q.push_back(32'hA9AAABAC);
        wait_cnt(2, 60, "b2b_done");
        repeat (2) step();
        chk("b2b_rd_cycles", rd_total, 32'd8);
        chk("b2b_count", {16'd0, pkt_count}, 32'd2);
        chk("b2b_idle_then_rd", first_rd - start_cyc, 32'd2);
        chk("b2b_latency", rise_cyc[0] - first_rd, 32'd8);
        chk("b2b_period", rise_cyc[1] - rise_cyc[0], 32'd9);

        // Underflow mid-packet
        push(8'h10);
        push(8'h20);
        exp_q.push_back(32'h10203040);
        repeat (8) step();
        rd_total = 0;
        repeat (20) step();
        chk("underflow_rd", rd_total, 32'd0);
        chk("underflow_valid", {31'd0, out_valid}, 32'd0);
        push(8'h30);
        push(8'h40);
        wait_cnt(3, 40, "underflow_done");
        chk("underflow_count", {16'd0, pkt_count}, 32'd3);

        // Backpressure in OUT with more data waiting
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(8'h51 + i));
        for (int i = 0; i < 4; i++) push(8'(8'h61 + i));
        exp_q.push_back(32'h51525354);
        exp_q.push_back(32'h61626364);
        wait_vld(40, "bp_valid");
        chk("bp_word", out_word, 32'h51525354);
        rd_total = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_word", out_word, 32'h51525354);
        end
        chk("bp_rd", rd_total, 32'd0);
        chk("bp_count_held", {16'd0, pkt_count}, 32'd3);
        out_ready = 1'b1;
        step();
        chk("bp_count_once", {16'd0, pkt_count}, 32'd4);
        wait_cnt(5, 40, "bp_done");
        chk("bp_count_final", {16'd0, pkt_count}, 32'd5);
        chk("wrap_count", {30'd0, pkt_count2}, 32'd1);

        // Flush after three bytes, then flush during CAPTURE, then a clean packet
        push(8'hE1);
        push(8'hE2);
        push(8'hE3);
        repeat (10) step();
        flush = 1'b1;
        push(8'hF1);
        #1;
        chk("flush_rd_forced", {31'd0, rd}, 32'd0);
        step();
        flush = 1'b0;
        repeat (2) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 1; i <= 4; i++) push(8'(i));
        exp_q.push_back(32'h01020304);
        wait_cnt(6, 40, "flush_done");
        chk("flush_count", {16'd0, pkt_count}, 32'd6);

        // Flush while a word waits in OUT is ignored
        out_ready = 1'b0;
        push(8'h0A);
        push(8'h0B);
        push(8'h0C);
        push(8'h0D);
        exp_q.push_back(32'h0A0B0C0D);
        wait_vld(40, "flush_out_valid");
        flush = 1'b1;
        repeat (3) step();
        chk("flush_out_hold", {31'd0, out_valid}, 32'd1);
        chk("flush_out_word", out_word, 32'h0A0B0C0D);
        out_ready = 1'b1;
        wait_cnt(7, 10, "flush_out_done");
        flush = 1'b0;
        chk("flush_out_count", {16'd0, pkt_count}, 32'd7);

        // Reset mid-packet after two bytes, then a fresh packet
        step();
        push(8'h99);
        push(8'h98);
        repeat (8) step();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_rd", {31'd0, rd}, 32'd0);
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_word", out_word, 32'd0);
        chk("rst_mid_count", {16'd0, pkt_count}, 32'd0);
        chk("rst_mid_count_wrap", {30'd0, pkt_count2}, 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        exp_q.push_back(32'h11223344);
        wait_cnt(1, 40, "rst_resume_done");
        chk("rst_resume_count", {16'd0, pkt_count}, 32'd1);
        repeat (2) step();
        chk("all_words_seen", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
